// File: rtl/mul_exec_pkg.sv
// mul_exec_pkg: decode constants, functional-unit encoding and the per-stage
// payload type shared by the multiply pipeline.
package mul_exec_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  typedef enum logic [1:0] {
    FU_ALU_MISC = 2'b00,
    FU_MEM = 2'b01,
    FU_MULT = 2'b10,
    FU_NONE = 2'b11
  } fu_e;
  localparam int PROD_W = 64;
  localparam int STAGES_MIN = 3;
  localparam int STAGES_MAX = 8;
  // data is reused per stage: {|A|,|B|}, then four partial products, then the product
  typedef struct packed {
    logic v;
    logic [4:0] rd;
    logic wr;
    logic sign;
    logic [2*PROD_W-1:0] data;
  } stage_t;
  localparam int STAGE_W = $bits(stage_t);
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/mul_stage_reg.sv
// mul_stage_reg: one pipeline stage register that holds while the pipe is stalled.
module mul_stage_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         adv_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q_q <= '0;
    else if (adv_i) q_q <= d_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/mul_exec.sv
// mul_exec: STAGES-deep pipelined 32x32 signed/unsigned multiply with a
// valid/ack writeback handshake and in-flight destination tracking.
module mul_exec
  import mul_exec_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_mul_oper,
  input  logic [31:0] iss_ex_rega,
  input  logic [31:0] iss_ex_regb,
  input  logic        iss_ex_unsig,
  input  logic [4:0]  iss_ex_regdest,
  input  logic        iss_ex_writereg,
  input  logic        wb_mul_ack,
  output logic        mul_wb_valid,
  output logic [31:0] mul_wb_lo,
  output logic [31:0] mul_wb_hi,
  output logic [4:0]  mul_wb_regdest,
  output logic        mul_wb_writereg,
  output logic        mul_stall,
  output logic [31:0] mul_pending_mask,
  output logic [3:0]  mul_count
);
  stage_t s_d [1:STAGES];
  stage_t s_q [1:STAGES];
  logic adv;
  logic [31:0] a_mag, b_mag;
  logic [15:0] a_hi, a_lo, b_hi, b_lo;
  logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [63:0] sum;
  logic unused;
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mul_exec: STAGES out of range");
  end
  assign adv = ~s_q[STAGES].v | wb_mul_ack;
  assign mul_stall = s_q[STAGES].v & ~wb_mul_ack;
  assign a_mag = mag32(iss_ex_rega, ~iss_ex_unsig & iss_ex_rega[31]);
  assign b_mag = mag32(iss_ex_regb, ~iss_ex_unsig & iss_ex_regb[31]);
  assign {a_hi, a_lo, b_hi, b_lo} = s_q[1].data[63:0];
  assign pp_ll = {16'b0, a_lo} * {16'b0, b_lo};
  assign pp_lh = {16'b0, a_lo} * {16'b0, b_hi};
  assign pp_hl = {16'b0, a_hi} * {16'b0, b_lo};
  assign pp_hh = {16'b0, a_hi} * {16'b0, b_hi};
  // stage 2 data layout: {hh, hl, lh, ll}
  assign sum = {s_q[2].data[127:96], 32'b0}
             + {16'b0, s_q[2].data[95:64], 16'b0}
             + {16'b0, s_q[2].data[63:32], 16'b0}
             + {32'b0, s_q[2].data[31:0]};
  always_comb begin
    s_d[1].v = iss_mul_oper;
    s_d[1].rd = iss_ex_regdest;
    s_d[1].wr = iss_ex_writereg;
    s_d[1].sign = ~iss_ex_unsig & (iss_ex_rega[31] ^ iss_ex_regb[31]);
    s_d[1].data = {64'b0, a_mag, b_mag};
    s_d[2] = s_q[1];
    s_d[2].data = {pp_hh, pp_hl, pp_lh, pp_ll};
    s_d[3] = s_q[2];
    s_d[3].data = {64'b0, s_q[2].sign ? -sum : sum};
    for (int i = 4; i <= STAGES; i++) s_d[i] = s_q[i-1];
  end
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    mul_stage_reg #(.W(STAGE_W)) u_reg (
      .clock (clock),
      .reset (reset),
      .adv_i (adv),
      .d_i   (s_d[k]),
      .q_o   (s_q[k])
    );
  end
  assign mul_wb_valid = s_q[STAGES].v;
  assign mul_wb_lo = s_q[STAGES].v ? s_q[STAGES].data[31:0] : '0;
  assign mul_wb_hi = s_q[STAGES].v ? s_q[STAGES].data[63:32] : '0;
  assign mul_wb_regdest = s_q[STAGES].v ? s_q[STAGES].rd : '0;
  assign mul_wb_writereg = s_q[STAGES].v & s_q[STAGES].wr;
  always_comb begin
    mul_pending_mask = '0;
    mul_count = '0;
    for (int i = 1; i <= STAGES; i++) begin
      if (s_q[i].v && s_q[i].wr) mul_pending_mask[s_q[i].rd] = 1'b1;
      mul_count = mul_count + 4'(s_q[i].v);
    end
    mul_pending_mask[0] = 1'b0;
  end
  assign unused = ^{s_q[1].data[127:64], s_q[STAGES].data[127:64], s_q[STAGES].sign};
endmodule

// File: tb/tb_mul_exec.sv
// tb_mul_exec: randomized and directed stimulus against a queue-based reference
// of the multiply unit, checked by an independent negedge monitor.
module tb_mul_exec;
  localparam int STAGES = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iss_mul_oper = 1'b0;
  logic [31:0] iss_ex_rega = '0;
  logic [31:0] iss_ex_regb = '0;
  logic iss_ex_unsig = 1'b0;
  logic [4:0] iss_ex_regdest = '0;
  logic iss_ex_writereg = 1'b0;
  logic wb_mul_ack = 1'b1;
  logic mul_wb_valid, mul_wb_writereg, mul_stall;
  logic [31:0] mul_wb_lo, mul_wb_hi, mul_pending_mask;
  logic [4:0] mul_wb_regdest;
  logic [3:0] mul_count;

  mul_exec #(.STAGES(STAGES)) dut (
    .clock(clock), .reset(reset), .iss_mul_oper(iss_mul_oper),
    .iss_ex_rega(iss_ex_rega), .iss_ex_regb(iss_ex_regb),
    .iss_ex_unsig(iss_ex_unsig), .iss_ex_regdest(iss_ex_regdest),
    .iss_ex_writereg(iss_ex_writereg), .wb_mul_ack(wb_mul_ack),
    .mul_wb_valid(mul_wb_valid), .mul_wb_lo(mul_wb_lo), .mul_wb_hi(mul_wb_hi),
    .mul_wb_regdest(mul_wb_regdest), .mul_wb_writereg(mul_wb_writereg),
    .mul_stall(mul_stall), .mul_pending_mask(mul_pending_mask),
    .mul_count(mul_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] p;
    logic [4:0] rd;
    logic wr;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic u);
    longint x, y;
    if (u) return {32'b0, a} * {32'b0, b};
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  function automatic logic [31:0] qmask();
    logic [31:0] m = '0;
    foreach (sb[i]) if (sb[i].wr && sb[i].rd != 5'd0) m[sb[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares the presented result to the oldest accepted op, then
  // applies the handshake that will happen at the coming edge.
  always @(negedge clock) begin
    if (reset) sb.delete();
    else begin
      chk("count", 64'(mul_count), 64'(sb.size()));
      chk("pending_mask", 64'(mul_pending_mask), 64'(qmask()));
      chk("stall", 64'(mul_stall), 64'(mul_wb_valid & ~wb_mul_ack));
      if (mul_wb_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got valid=1 expected no op in flight");
        end else begin
          chk("product", {mul_wb_hi, mul_wb_lo}, sb[0].p);
          chk("regdest", 64'(mul_wb_regdest), 64'(sb[0].rd));
          chk("writereg", 64'(mul_wb_writereg), 64'(sb[0].wr));
        end
      end else begin
        chk("idle_hilo", {mul_wb_hi, mul_wb_lo}, 64'd0);
        chk("idle_tag", 64'({mul_wb_writereg, mul_wb_regdest}), 64'd0);
      end
      if (mul_wb_valid && wb_mul_ack && sb.size() > 0) void'(sb.pop_front());
      if (iss_mul_oper && !(mul_wb_valid && !wb_mul_ack))
        sb.push_back('{model_prod(iss_ex_rega, iss_ex_regb, iss_ex_unsig), iss_ex_regdest, iss_ex_writereg});
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u,
                       input logic [4:0] rd, input logic wr);
    logic st;
    iss_ex_rega = a;
    iss_ex_regb = b;
    iss_ex_unsig = u;
    iss_ex_regdest = rd;
    iss_ex_writereg = wr;
    iss_mul_oper = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clock);
      st = mul_wb_valid & ~wb_mul_ack;
      @(posedge clock);
      #1;
      if (!st) break;
      if (n == 200) begin
        tests++;
        fails++;
        $display("FAIL issue_timeout: stall still 1 after %0d cycles, required 0", n);
        break;
      end
    end
    iss_mul_oper = 1'b0;
  endtask

  task automatic expect_result(input string n, input logic [63:0] p, input logic [4:0] rd);
    for (int k = 1; k < STAGES; k++) begin
      @(posedge clock);
      #1;
      if (k < STAGES - 1) chk({n, "_early"}, 64'(mul_wb_valid), 64'd0);
    end
    chk({n, "_valid"}, 64'(mul_wb_valid), 64'd1);
    chk({n, "_hilo"}, {mul_wb_hi, mul_wb_lo}, p);
    chk({n, "_rd"}, 64'(mul_wb_regdest), 64'(rd));
    @(posedge clock);
    #1;
    chk({n, "_retired"}, 64'(mul_wb_valid), 64'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && mul_count != 0; n++) begin
      @(posedge clock);
      #1;
    end
    chk("drain", 64'(mul_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] held;
    int nvalid, first, last, maxc;
    logic [31:0] mu;
    #2;
    chk("reset_valid", 64'(mul_wb_valid), 64'd0);
    chk("reset_hilo", {mul_wb_hi, mul_wb_lo}, 64'd0);
    chk("reset_stall", 64'(mul_stall), 64'd0);
    chk("reset_mask", 64'(mul_pending_mask), 64'd0);
    chk("reset_count", 64'(mul_count), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1);
    expect_result("umax", 64'hFFFF_FFFE_0000_0001, 5'd3);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd4, 1'b1);
    expect_result("smin", 64'h4000_0000_0000_0000, 5'd4);
    issue(32'hFFFF_FFFD, 32'd7, 1'b0, 5'd5, 1'b1);
    expect_result("neg3x7", 64'hFFFF_FFFF_FFFF_FFEB, 5'd5);

    issue(32'd11, 32'd13, 1'b1, 5'd5, 1'b1);
    issue(32'hFFFF_FF00, 32'd3, 1'b0, 5'd6, 1'b1);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd7, 1'b1);
    nvalid = 0; first = -1; last = -1; maxc = 0; mu = '0;
    for (int c = 0; c < 8; c++) begin
      if (mul_wb_valid) begin
        nvalid++;
        if (first < 0) first = c;
        last = c;
      end
      if (int'(mul_count) > maxc) maxc = int'(mul_count);
      mu |= mul_pending_mask;
      @(posedge clock);
      #1;
    end
    chk("b2b_valid_cycles", 64'(nvalid), 64'd3);
    chk("b2b_consecutive", 64'(last - first), 64'd2);
    chk("b2b_peak_count", 64'(maxc), 64'd3);
    chk("b2b_mask_union", 64'(mu), 64'h0000_00E0);

    wb_mul_ack = 1'b0;
    for (int i = 0; i < STAGES; i++) issue($urandom, $urandom, 1'(i % 2), 5'(10 + i), 1'b1);
    chk("bp_stall", 64'(mul_stall), 64'd1);
    chk("bp_count_full", 64'(mul_count), 64'(STAGES));
    held = {mul_wb_writereg, mul_wb_regdest, mul_wb_hi};
    iss_ex_rega = 32'd99;
    iss_ex_regb = 32'd77;
    iss_ex_regdest = 5'd20;
    iss_mul_oper = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("bp_hold_stall", 64'(mul_stall), 64'd1);
      chk("bp_hold_count", 64'(mul_count), 64'(STAGES));
      chk("bp_hold_out", 64'({mul_wb_writereg, mul_wb_regdest, mul_wb_hi}), 64'(held));
    end
    iss_mul_oper = 1'b0;
    wb_mul_ack = 1'b1;
    @(posedge clock);
    #1;
    wb_mul_ack = 1'b0;
    chk("bp_one_retire_count", 64'(mul_count), 64'(STAGES - 1));
    chk("bp_one_retire_valid", 64'(mul_wb_valid), 64'd1);
    wb_mul_ack = 1'b1;
    drain();

    issue(32'd5, 32'd6, 1'b1, 5'd9, 1'b0);
    chk("nowrite_mask", 64'(mul_pending_mask), 64'd0);
    issue(32'd7, 32'd8, 1'b0, 5'd0, 1'b1);
    chk("r0_mask", 64'(mul_pending_mask), 64'd0);
    chk("r0_count", 64'(mul_count), 64'd2);
    drain();

    for (int c = 0; c < 400; c++) begin
      wb_mul_ack = ($urandom_range(0, 9) < 7);
      iss_mul_oper = ($urandom_range(0, 9) < 6);
      iss_ex_rega = pick();
      iss_ex_regb = pick();
      iss_ex_unsig = 1'($urandom_range(0, 1));
      iss_ex_regdest = 5'($urandom_range(0, 31));
      iss_ex_writereg = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    iss_mul_oper = 1'b0;
    wb_mul_ack = 1'b1;
    drain();

    issue(32'd2, 32'd3, 1'b1, 5'd1, 1'b1);
    issue(32'd4, 32'd5, 1'b1, 5'd2, 1'b1);
    issue(32'd6, 32'd7, 1'b1, 5'd3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_count", 64'(mul_count), 64'd0);
    chk("rst_mid_mask", 64'(mul_pending_mask), 64'd0);
    chk("rst_mid_valid", 64'(mul_wb_valid), 64'd0);
    chk("rst_mid_hilo", {mul_wb_hi, mul_wb_lo}, 64'd0);
    chk("rst_mid_stall", 64'(mul_stall), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      chk("post_rst_quiet", 64'(mul_wb_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
